// File: rtl/data_sram_responder_if.sv
// Data SRAM port bundle between the core's memory stage (master) and the responder (slave).
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-addressed RAM plus a config window (timer, LED, NUM, switches, scratch).
module data_sram_responder #(
   parameter int unsigned RAM_AW    = 12,
   parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
   input  logic                       clk,
   input  logic                       resetn,
   data_sram_responder_if.slave       bus,
   input  logic [7:0]                 switch,
   output logic [15:0]                led,
   output logic [31:0]                num_data
);

   localparam logic [15:0] OFF_TIMER   = 16'he000;
   localparam logic [15:0] OFF_LED     = 16'hf000;
   localparam logic [15:0] OFF_NUM     = 16'hf010;
   localparam logic [15:0] OFF_SWITCH  = 16'hf020;
   localparam logic [15:0] OFF_SCRATCH = 16'hf030;

   logic [31:0]       ram [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic [15:0]       offset;
   logic              is_conf;
   logic              req_rd;
   logic              req_wr;
   logic              conf_wr;
   logic [31:0]       conf_rd;
   logic [31:0]       timer;
   logic [31:0]       scratch;
   logic [7:0]        sw_meta;
   logic [7:0]        sw_sync;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   assign ram_idx = bus.data_sram_addr[RAM_AW+1:2];
   assign offset  = bus.data_sram_addr[15:0];
   assign is_conf = (bus.data_sram_addr[31:16] == CONF_BASE[31:16]);
   assign req_rd  = bus.data_sram_en && (bus.data_sram_we == '0);
   assign req_wr  = bus.data_sram_en && (bus.data_sram_we != '0);
   assign conf_wr = req_wr && is_conf;

   // RAM contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (req_wr && !is_conf) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_we[i]) ram[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      conf_rd = '0;
      unique case (offset)
         OFF_TIMER:   conf_rd = timer;
         OFF_LED:     conf_rd = {16'h0000, led};
         OFF_NUM:     conf_rd = num_data;
         OFF_SWITCH:  conf_rd = {24'h000000, sw_sync};
         OFF_SCRATCH: conf_rd = scratch;
         default:     conf_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.data_sram_rdata <= '0;
      end else if (req_rd) begin
         bus.data_sram_rdata <= is_conf ? conf_rd : ram[ram_idx];
      end
   end

   // A timer write replaces that cycle's increment; counting resumes on the next edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer <= '0;
      end else if (conf_wr && offset == OFF_TIMER) begin
         timer <= byte_merge(timer, bus.data_sram_wdata, bus.data_sram_we);
      end else begin
         timer <= timer + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led      <= '0;
         num_data <= '0;
         scratch  <= '0;
      end else if (conf_wr) begin
         if (offset == OFF_LED) begin
            if (bus.data_sram_we[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
            if (bus.data_sram_we[1]) led[15:8] <= bus.data_sram_wdata[15:8];
         end
         if (offset == OFF_NUM)
            num_data <= byte_merge(num_data, bus.data_sram_wdata, bus.data_sram_we);
         if (offset == OFF_SCRATCH)
            scratch <= byte_merge(scratch, bus.data_sram_wdata, bus.data_sram_we);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switch;
         sw_sync <= sw_meta;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: reads push expected data, a monitor compares rdata.
module tb_data_sram_responder;

   logic        clk;
   logic        resetn;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;

   data_sram_responder_if bus();

   data_sram_responder #(.RAM_AW(12), .CONF_BASE(32'hbfaf_0000)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .switch   (switch),
      .led      (led),
      .num_data (num_data)
   );

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] exp_q [$];
   string       name_q [$];
   logic        rd_pending;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a read accepted at a rising edge is checked at the following falling edge.
   always @(posedge clk)
      rd_pending = resetn && bus.data_sram_en && (bus.data_sram_we == 4'h0);

   always @(negedge clk) begin
      if (rd_pending) begin
         rd_pending = 1'b0;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rdata_unexpected: got %h expected no read", bus.data_sram_rdata);
         end else begin
            chk(name_q.pop_front(), bus.data_sram_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      bus.data_sram_en = 1'b0;
      bus.data_sram_we = 4'h0;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      bus.data_sram_en    = 1'b1;
      bus.data_sram_we    = we;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = data;
      @(posedge clk);
      #1;
      bus.data_sram_en = 1'b0;
      bus.data_sram_we = 4'h0;
   endtask

   task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
      bus.data_sram_en    = 1'b1;
      bus.data_sram_we    = 4'h0;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = 32'h0;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      bus.data_sram_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks            = 0;
      n_fail              = 0;
      rd_pending          = 1'b0;
      resetn              = 1'b0;
      switch              = 8'h00;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_we    = 4'h0;
      bus.data_sram_addr  = 32'h0;
      bus.data_sram_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", bus.data_sram_rdata, 32'h0);
      chk("reset_led", {16'h0, led}, 32'h0);
      chk("reset_num", num_data, 32'h0);
      resetn = 1'b1;

      // RAM byte enables and read latency
      wr(32'h0000_0040, 32'h1234_5678, 4'hf);
      wr(32'h0000_0040, 32'h0000_aa00, 4'b0010);
      rd("ram_byte_merge", 32'h0000_0040, 32'h1234_aa78);
      bus.data_sram_en    = 1'b0;
      bus.data_sram_we    = 4'hf;
      bus.data_sram_addr  = 32'h0000_0040;
      bus.data_sram_wdata = 32'h0;
      @(posedge clk);
      #1;
      rd("ram_en0_ignored", 32'h0000_0040, 32'h1234_aa78);
      wr(32'h0000_0100, 32'hdead_beef, 4'hf);
      rd("ram_wr_then_rd", 32'h0000_0100, 32'hdead_beef);
      rd("ram_alias", 32'h0000_4100, 32'hdead_beef);
      idle();
      rd("rdata_hold_check", 32'h0000_0040, 32'h1234_aa78);

      // Config registers
      wr(32'hbfaf_f000, 32'hffff_a5a5, 4'hf);
      chk("led_out", {16'h0, led}, 32'h0000_a5a5);
      rd("led_readback", 32'hbfaf_f000, 32'h0000_a5a5);
      wr(32'hbfaf_f010, 32'h0000_0007, 4'hf);
      chk("num_out", num_data, 32'h0000_0007);
      wr(32'hbfaf_f030, 32'hcafe_f00d, 4'hf);
      wr(32'hbfaf_f030, 32'h1100_0000, 4'b1000);
      rd("scratch_merge", 32'hbfaf_f030, 32'h11fe_f00d);

      // Timer load, increment and wrap
      wr(32'hbfaf_e000, 32'h0000_0010, 4'hf);
      idle();
      idle();
      rd("timer_load", 32'hbfaf_e000, 32'h0000_0012);
      wr(32'hbfaf_e000, 32'hffff_ffff, 4'hf);
      idle();
      rd("timer_wrap", 32'hbfaf_e000, 32'h0000_0000);

      // Switch synchronizer, read-only and unmapped offsets
      switch = 8'h5c;
      repeat (3) idle();
      rd("switch_read", 32'hbfaf_f020, 32'h0000_005c);
      wr(32'hbfaf_f020, 32'h0000_0001, 4'hf);
      rd("switch_ro", 32'hbfaf_f020, 32'h0000_005c);
      rd("unmapped", 32'hbfaf_1234, 32'h0000_0000);

      // Asynchronous reset mid-run
      wr(32'hbfaf_f000, 32'h0000_00ff, 4'h3);
      wr(32'hbfaf_f010, 32'h0000_0005, 4'hf);
      chk("led_pre_reset", {16'h0, led}, 32'h0000_00ff);
      chk("num_pre_reset", num_data, 32'h0000_0005);
      rd("rd_pre_reset", 32'h0000_0100, 32'hdead_beef);
      @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("async_rst_rdata", bus.data_sram_rdata, 32'h0);
      chk("async_rst_led", {16'h0, led}, 32'h0);
      chk("async_rst_num", num_data, 32'h0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      idle();
      idle();
      rd("timer_after_reset", 32'hbfaf_e000, 32'h0000_0002);

      repeat (3) idle();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
